// File: rtl/mcpu_io_uart.sv
// Memory-mapped UART slave for the 8-bit CPU bus: status/data registers, TX FIFO + transmitter.
// Define MCPU_UART_RX_EN to build the optional receiver; without it rxd is ignored.
module mcpu_io_uart #(
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [5:0]  ADDR_STAT  = 6'h3E,
  parameter logic [5:0]  ADDR_DATA  = 6'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] adress,
  inout  wire  [7:0] data,
  input  logic       oe,
  input  logic       we,
  output logic       ram_sel,
  output logic       txd,
  input  logic       rxd,
  output logic       tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus handshake: there is no valid/ready pair. A write is valid for exactly the
  // edge where we==0 and the address hits this block, and it is always "ready"
  // (a full FIFO drops the byte and raises tx_ovf). Reads are combinational and
  // only the ADDR_DATA read has an edge side effect (clearing rx_valid).
  logic sel_stat, sel_data, io_sel;
  logic wr_stat, wr_data;
  logic [7:0] status, rdata;

  assign sel_stat = (adress == ADDR_STAT);
  assign sel_data = (adress == ADDR_DATA);
  assign io_sel   = sel_stat | sel_data;
  assign ram_sel  = ~io_sel;
  assign wr_stat  = ~we & sel_stat;
  assign wr_data  = ~we & sel_data;

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        fifo_empty, fifo_full;
  logic        tx_pop, push_ok, push_drop;
  logic [7:0]  fifo_head;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fifo_head  = fifo_mem[rptr[AW-1:0]];
  assign push_ok    = wr_data & (~fifo_full | tx_pop);
  assign push_drop  = wr_data & fifo_full & ~tx_pop;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (tx_pop)  rptr <= rptr + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  state_t      tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        txd_r;
  logic        tx_ovf;
  logic        tx_idle;

  // A pop happens from IDLE, or at the last cycle of STOP so frames chain without a gap.
  assign tx_pop  = ~fifo_empty & ((tx_state == S_IDLE) |
                                  ((tx_state == S_STOP) & (tx_cnt == '0)));
  assign tx_idle = fifo_empty & (tx_state == S_IDLE);
  assign tx_busy = ~tx_idle;
  assign txd     = txd_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd_r    <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_shift <= fifo_head;
            txd_r    <= 1'b0;
            tx_cnt   <= BIT_RELOAD;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
          end else begin
            txd_r    <= tx_shift[0];
            tx_cnt   <= BIT_RELOAD;
            tx_idx   <= '0;
            tx_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
          end else begin
            tx_cnt <= BIT_RELOAD;
            if (tx_idx == 3'd7) begin
              txd_r    <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd_r    <= tx_shift[1];
            end
          end
        end
        S_STOP: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
          end else if (tx_pop) begin
            tx_shift <= fifo_head;
            txd_r    <= 1'b0;
            tx_cnt   <= BIT_RELOAD;
            tx_state <= S_START;
          end else begin
            tx_state <= S_IDLE;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)           tx_ovf <= 1'b0;
    else if (wr_stat)   tx_ovf <= 1'b0;
    else if (push_drop) tx_ovf <= 1'b1;
  end

  // ---------------- RX path ----------------
  logic       rx_valid, rx_err;
  logic [7:0] rx_hold;

`ifdef MCPU_UART_RX_EN
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_s1, rx_s2, rx_s3;
  logic          rd_data;

  assign rd_data = ~oe & sel_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Flag clears are written first so a same-edge load or error set takes priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_hold  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      if (rd_data) rx_valid <= 1'b0;
      if (wr_stat) rx_err   <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_s3 & ~rx_s2) begin
            rx_cnt   <= HALF_RELOAD;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else if (rx_s2) begin
            rx_state <= S_IDLE;
          end else begin
            rx_cnt   <= BIT_RELOAD;
            rx_idx   <= '0;
            rx_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_RELOAD;
            if (rx_idx == 3'd7) rx_state <= S_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_state <= S_IDLE;
            if (rx_s2 && !rx_valid) begin
              rx_hold  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end
`else
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_valid   = 1'b0;
  assign rx_err     = 1'b0;
  assign rx_hold    = 8'h00;
`endif

  // ---------------- Read mux ----------------
  assign status = {fifo_full, rx_valid, tx_idle, 3'b000, rx_err, tx_ovf};
  assign rdata  = sel_stat ? status : rx_hold;
  assign data   = (~oe & we & io_sel) ? rdata : 8'bz;

endmodule

// File: doc/mcpu_io_uart.md
Name: mcpu_io_uart

Overview:
- Memory-mapped serial I/O slave on the 8-bit CPU's shared bus: 6-bit adress, bidirectional data, active-low oe/we strobes.
- Claims two addresses at the top of the 64-byte space (status, data). Contains a TX FIFO, a UART transmitter and an optional UART receiver.
- Generates ram_sel so the external RAM ignores cycles aimed at the I/O addresses.

Parameters:
- CLK_DIV, 16: clk cycles per serial bit; must be >= 4 and even.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of two, >= 2.
- ADDR_STAT, 6'h3E: status register address.
- ADDR_DATA, 6'h3F: data register address.

Ports:
- clk  in  1  Block clock. This is the inverted CPU clock, so each rising edge falls mid-way through the CPU low phase while the strobes are stable.
- rst  in  1  Synchronous reset, active-low, sampled on rising clk.
- adress  in  6  CPU address.
- data  inout  8  CPU data bus.
- oe  in  1  CPU read strobe, active-low.
- we  in  1  CPU write strobe, active-low.
- ram_sel  out  1  High when adress is neither ADDR_STAT nor ADDR_DATA (combinational).
- txd  out  1  Serial out; idles high.
- rxd  in  1  Serial in; asynchronous.
- tx_busy  out  1  High while the FIFO is non-empty or the shifter is active.

Behaviour:
- Reset (rst=0 at an edge):
  - FIFO is emptied; TX and RX FSMs go to IDLE.
  - txd=1, tx_busy=0, all status flags are 0, rx holding register is 0x00.
  - A reset mid-frame aborts the frame; txd is high after that edge.
- Bus decode: io_sel = (adress==ADDR_STAT)|(adress==ADDR_DATA).
- Read data drive:
  - data = rdata when (~oe & io_sel), else 8'bZ. Combinational, no wait states.
  - The block never drives data while we is low.
- Write: commits at an edge where we==0 and io_sel.
  - ADDR_DATA: push data into the FIFO.
  - ADDR_STAT: any write clears both sticky flags.
- Status byte:
  - bit7 tx_full, bit6 rx_valid, bit5 tx_idle (FIFO empty and FSM IDLE).
  - bit1 rx_err (sticky), bit0 tx_ovf (sticky), bits4..2 = 0.
  - bit7 = full lets software poll with ADD 0x80 and branch on carry.
- FIFO push/pop:
  - A push is accepted if the FIFO is not full, or if a pop occurs at the same edge.
  - Otherwise the push is dropped and tx_ovf is set.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE with the FIFO non-empty at edge N: pop at N. txd=0 from edge N+1 (START).
  - Each bit lasts exactly CLK_DIV cycles, timed by a down-counter reloaded with CLK_DIV-1.
  - DATA sends bits LSB first, 8 bits, counted by a 3-bit index.
  - STOP holds txd=1 for one bit.
  - STOP -> START directly if the FIFO is non-empty (back-to-back frames, no idle gap).
  - A frame is 10*CLK_DIV cycles.
- RX FSM (only with MCPU_UART_RX_EN): IDLE -> START -> DATA -> STOP.
  - rxd passes through a 2-flop synchroniser; a falling edge enters START.
  - START: after CLK_DIV/2 cycles, if the line is high, return to IDLE (glitch).
  - DATA: samples every CLK_DIV cycles thereafter, LSB first.
  - STOP: sample=1 with rx_valid=0 -> load the holding register and set rx_valid.
  - STOP: sample=0 -> byte discarded, rx_err set.
  - STOP: sample=1 with rx_valid=1 -> new byte discarded, old byte kept, rx_err set.
  - A read of ADDR_DATA (oe==0 at the edge) clears rx_valid at that edge.
  - If the clear and a new byte load coincide, the load wins and rx_valid stays 1.
- Reading ADDR_DATA returns the rx holding register.
- Status reads have no side effects.

Optional Feature:
- MCPU_UART_RX_EN defined: RX path as described.
- MCPU_UART_RX_EN undefined:
  - No RX logic; rxd is ignored.
  - rx_valid and rx_err read 0.
  - ADDR_DATA reads 0x00.

Test Plan:
- Reset, then read ADDR_STAT -> data=0x20, txd=1, tx_busy=0, ram_sel=0. With adress=0x10 -> ram_sel=1, data=Z.
- CLK_DIV=16, write 0xA5 to ADDR_DATA -> txd goes low one edge later. Then 1,0,1,0,0,1,0,1, then stop=1; each bit 16 cycles; tx_busy drops after 160 cycles.
- Five writes back-to-back while TX is busy (depth 4) -> fifth write dropped, status bit7=1, bit0=1. Write ADDR_STAT -> bit0 clears. Four frames follow with no idle gap.
- RX_EN: drive 0x3C at CLK_DIV rate -> status bit6=1. Read ADDR_DATA -> data=0x3C; next status read shows bit6=0.
- RX_EN: stop bit driven 0 -> bit6 stays 0, bit1=1. A second byte arriving while bit6=1 -> first byte retained, bit1=1.
- Assert rst mid-TX frame -> txd=1 after that edge, FIFO empty, status=0x20.
